// File: rtl/gon_sched_ctrl.sv
// GON sequencer: scan-loads the row/ID chains, then walks the (row, col) window and streams opsums out.
// Optional watchdog with timeout_err port: define GON_SCHED_TIMEOUT_EN.
module gon_sched_ctrl #(
    parameter int unsigned XBUS_NUMS = 12,
    parameter int unsigned PE_NUMS   = 14,
    parameter int unsigned ID_LEN    = 5,
    parameter int unsigned ROW_LEN   = 4,
    parameter int unsigned VALUE_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 skip_cfg,
    input  logic [ROW_LEN-1:0]   num_rows,
    input  logic [ID_LEN-1:0]    num_cols,
    output logic                 set_row,
    output logic [ROW_LEN-1:0]   row_scan_in,
    output logic                 set_id,
    output logic [ID_LEN-1:0]    id_scan_in,
    output logic                 gon_ready,
    output logic [ROW_LEN-1:0]   row_tag,
    output logic [ID_LEN-1:0]    col_tag,
    input  logic                 gon_enable,
    input  logic [VALUE_LEN-1:0] gon_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VALUE_LEN-1:0] out_data,
    output logic [ROW_LEN-1:0]   out_row,
    output logic [ID_LEN-1:0]    out_col,
    output logic                 busy,
`ifdef GON_SCHED_TIMEOUT_EN
    output logic                 timeout_err,
`endif
    output logic                 done
);

    localparam logic [ROW_LEN-1:0] ROW_MAX = ROW_LEN'(XBUS_NUMS - 1);
    localparam logic [ID_LEN-1:0]  COL_MAX = ID_LEN'(PE_NUMS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN_ROW, S_SCAN_ID, S_SETTLE, S_REQ, S_WAIT_OUT, S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [ROW_LEN-1:0]   scan_bus_q, scan_bus_d;
    logic [ID_LEN-1:0]    scan_pe_q, scan_pe_d;
    logic [ROW_LEN-1:0]   last_row_q, last_row_d;
    logic [ID_LEN-1:0]    last_col_q, last_col_d;
    logic                 set_row_d, set_id_d, gon_ready_d, out_valid_d, busy_d, done_d;
    logic [ROW_LEN-1:0]   row_scan_in_d, row_tag_d, out_row_d;
    logic [ID_LEN-1:0]    id_scan_in_d, col_tag_d, out_col_d;
    logic [VALUE_LEN-1:0] out_data_d, cap_data;
    logic                 capture;

`ifdef GON_SCHED_TIMEOUT_EN
    localparam int unsigned WD_LEN = 10;
    localparam logic [WD_LEN-1:0] WD_MAX = '1;
    logic [WD_LEN-1:0] wd_q, wd_d;
    logic              timeout_err_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        scan_bus_d  = scan_bus_q;
        scan_pe_d   = scan_pe_q;
        last_row_d  = last_row_q;
        last_col_d  = last_col_q;
        row_tag_d   = row_tag;
        col_tag_d   = col_tag;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_row_d   = out_row;
        out_col_d   = out_col;
        gon_ready_d = 1'b0;
        done_d      = 1'b0;
        capture     = 1'b0;
        cap_data    = gon_value;
`ifdef GON_SCHED_TIMEOUT_EN
        wd_d          = wd_q;
        timeout_err_d = timeout_err;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows == '0)                          last_row_d = '0;
                    else if (num_rows >= ROW_LEN'(XBUS_NUMS))    last_row_d = ROW_MAX;
                    else                                         last_row_d = num_rows - ROW_LEN'(1);
                    if (num_cols == '0)                          last_col_d = '0;
                    else if (num_cols >= ID_LEN'(PE_NUMS))       last_col_d = COL_MAX;
                    else                                         last_col_d = num_cols - ID_LEN'(1);
                    scan_bus_d  = '0;
                    scan_pe_d   = '0;
                    row_tag_d   = '0;
                    col_tag_d   = '0;
                    out_valid_d = 1'b0;
`ifdef GON_SCHED_TIMEOUT_EN
                    wd_d          = '0;
                    timeout_err_d = 1'b0;
`endif
                    state_d = skip_cfg ? S_REQ : S_SCAN_ROW;
                end
            end
            S_SCAN_ROW: begin
                if (scan_bus_q == ROW_MAX) begin
                    scan_bus_d = '0;
                    scan_pe_d  = '0;
                    state_d    = S_SCAN_ID;
                end else begin
                    scan_bus_d = scan_bus_q + ROW_LEN'(1);
                end
            end
            S_SCAN_ID: begin
                if (scan_pe_q == COL_MAX) begin
                    scan_pe_d = '0;
                    if (scan_bus_q == ROW_MAX) begin
                        scan_bus_d = '0;
                        state_d    = S_SETTLE;
                    end else begin
                        scan_bus_d = scan_bus_q + ROW_LEN'(1);
                    end
                end else begin
                    scan_pe_d = scan_pe_q + ID_LEN'(1);
                end
            end
            S_SETTLE: begin
                if (scan_pe_q == ID_LEN'(1)) begin
                    scan_pe_d = '0;
                    state_d   = S_REQ;
                end else begin
                    scan_pe_d = scan_pe_q + ID_LEN'(1);
                end
            end
            S_REQ: begin
                // A value is only taken once the request is actually on the wire
                gon_ready_d = 1'b1;
                if (gon_ready && gon_enable) capture = 1'b1;
`ifdef GON_SCHED_TIMEOUT_EN
                else if (gon_ready) begin
                    if (wd_q == WD_MAX) begin
                        capture       = 1'b1;
                        cap_data      = VALUE_LEN'(32'hDEAD_BEEF);
                        timeout_err_d = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_LEN'(1);
                    end
                end
                if (capture) wd_d = '0;
`endif
                if (capture) begin
                    gon_ready_d = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = cap_data;
                    out_row_d   = row_tag;
                    out_col_d   = col_tag;
                    if (row_tag == last_row_q && col_tag == last_col_q) begin
                        row_tag_d = '0;
                        col_tag_d = '0;
                        state_d   = S_FIN;
                    end else begin
                        if (col_tag == last_col_q) begin
                            col_tag_d = '0;
                            row_tag_d = row_tag + ROW_LEN'(1);
                        end else begin
                            col_tag_d = col_tag + ID_LEN'(1);
                        end
                        state_d = S_WAIT_OUT;
                    end
                end
            end
            S_WAIT_OUT: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_REQ;
                end
            end
            S_FIN: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        set_row_d     = (state_d == S_SCAN_ROW);
        row_scan_in_d = set_row_d ? ROW_MAX - scan_bus_d : '0;
        set_id_d      = (state_d == S_SCAN_ID);
        id_scan_in_d  = set_id_d ? COL_MAX - scan_pe_d : '0;
        busy_d        = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            scan_bus_q  <= '0;
            scan_pe_q   <= '0;
            last_row_q  <= '0;
            last_col_q  <= '0;
            set_row     <= 1'b0;
            row_scan_in <= '0;
            set_id      <= 1'b0;
            id_scan_in  <= '0;
            gon_ready   <= 1'b0;
            row_tag     <= '0;
            col_tag     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_row     <= '0;
            out_col     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef GON_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            scan_bus_q  <= scan_bus_d;
            scan_pe_q   <= scan_pe_d;
            last_row_q  <= last_row_d;
            last_col_q  <= last_col_d;
            set_row     <= set_row_d;
            row_scan_in <= row_scan_in_d;
            set_id      <= set_id_d;
            id_scan_in  <= id_scan_in_d;
            gon_ready   <= gon_ready_d;
            row_tag     <= row_tag_d;
            col_tag     <= col_tag_d;
            out_valid   <= out_valid_d;
            out_data    <= out_data_d;
            out_row     <= out_row_d;
            out_col     <= out_col_d;
            busy        <= busy_d;
            done        <= done_d;
`ifdef GON_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_err <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_gon_sched_ctrl.sv
// Randomized bench for gon_sched_ctrl: job-level reference model, GON responder and result sink.
module tb_gon_sched_ctrl;

    localparam int XB = 12;
    localparam int PE = 14;
    localparam int IDL = 5;
    localparam int RL = 4;
    localparam int VL = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic skip_cfg = 1'b0;
    logic [RL-1:0] num_rows = '0;
    logic [IDL-1:0] num_cols = '0;
    logic set_row, set_id, gon_ready, out_valid, busy, done;
    logic [RL-1:0] row_scan_in, row_tag, out_row;
    logic [IDL-1:0] id_scan_in, col_tag, out_col;
    logic gon_enable = 1'b0;
    logic [VL-1:0] gon_value = '0;
    logic out_ready = 1'b0;
    logic [VL-1:0] out_data;
`ifdef GON_SCHED_TIMEOUT_EN
    logic timeout_err;
`endif

    gon_sched_ctrl #(.XBUS_NUMS(XB), .PE_NUMS(PE), .ID_LEN(IDL), .ROW_LEN(RL), .VALUE_LEN(VL)) dut (
        .clk(clk), .rst(rst), .start(start), .skip_cfg(skip_cfg),
        .num_rows(num_rows), .num_cols(num_cols),
        .set_row(set_row), .row_scan_in(row_scan_in), .set_id(set_id), .id_scan_in(id_scan_in),
        .gon_ready(gon_ready), .row_tag(row_tag), .col_tag(col_tag),
        .gon_enable(gon_enable), .gon_value(gon_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .busy(busy),
`ifdef GON_SCHED_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RL-1:0]  r;
        logic [IDL-1:0] c;
        logic [VL-1:0]  d;
    } res_t;

    res_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int ready_mode = 1, ready_pct = 100, lat = 0, poke_cyc = -1;
    bit mute_all = 0, mute_00 = 0;
    logic [15:0] salt = '0;
    int row_idx, id_idx, last_id_cyc, first_req_cyc, first_valid_cyc, done_cnt;
    bit first_req_seen, first_valid_seen;
    logic [RL-1:0] first_r;
    logic [IDL-1:0] first_c;
    bit hold_started, released, rel_measured;
    int hold_left, release_cyc;
    bit prev_gr, prev_ge, prev_ov, prev_or;
    logic [RL-1:0] prev_rt, prev_row;
    logic [IDL-1:0] prev_ct, prev_col;
    logic [VL-1:0] prev_data;

    function automatic logic [VL-1:0] gon_val(input logic [RL-1:0] r, input logic [IDL-1:0] c);
        return {salt, 8'(r), 8'(c)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ctrl"}, {set_row, set_id, gon_ready, out_valid, busy, done}, 0);
        check({pfx, "_tags"}, {row_scan_in, id_scan_in, row_tag, col_tag, out_row, out_col}, 0);
        check({pfx, "_data"}, out_data, 0);
`ifdef GON_SCHED_TIMEOUT_EN
        check({pfx, "_tmo"}, timeout_err, 0);
`endif
    endtask

    // One clock: observe DUT after the edge, run GON/sink models, drive inputs for the next edge
    task automatic cycle();
        res_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (set_row) begin
            check("row_scan", row_scan_in, 64'(XB - 1 - row_idx));
            row_idx++;
        end
        if (set_id) begin
            check("id_scan", id_scan_in, 64'(PE - 1 - (id_idx % PE)));
            id_idx++;
            last_id_cyc = cyc;
        end
        if (gon_ready && !first_req_seen) begin
            first_req_seen = 1; first_req_cyc = cyc; first_r = row_tag; first_c = col_tag;
        end
        if (gon_ready && prev_gr && !prev_ge)
            check("req_tag_stable", {row_tag, col_tag}, {prev_rt, prev_ct});
        if (gon_ready && !prev_gr && released && !rel_measured) begin
            rel_measured = 1;
            check("release_to_req", (cyc - release_cyc) inside {[1:2]}, 1);
            check("release_tag", {row_tag, col_tag}, {4'd0, 5'd1});
        end
        if (out_valid) check("no_req_when_full", gon_ready, 0);
        if (out_valid && !first_valid_seen) begin
            first_valid_seen = 1; first_valid_cyc = cyc;
        end
        if (prev_ov && !prev_or)
            check("out_stable", {out_valid, out_row, out_col, out_data}, {1'b1, prev_row, prev_col, prev_data});
        if (done) begin
            done_cnt++;
            check("done_q_empty", exp_q.size(), 0);
        end
        // GON responder: random latency, value derived from the requested tags
        if (gon_ready) begin
            if (lat > 0) begin
                lat--; gon_enable = 1'b0;
            end else if (mute_all || (mute_00 && row_tag == '0 && col_tag == '0)) begin
                gon_enable = 1'b0;
            end else begin
                gon_enable = 1'b1; gon_value = gon_val(row_tag, col_tag);
            end
        end else begin
            gon_enable = 1'b0; lat = $urandom_range(0, 3); gon_value = $urandom;
        end
        // Result sink
        if (ready_mode == 0) out_ready = ($urandom_range(0, 99) < ready_pct);
        else if (ready_mode == 1) out_ready = 1'b1;
        else begin
            if (out_valid && !hold_started) begin hold_started = 1; hold_left = 20; end
            if (hold_started && hold_left > 0) begin out_ready = 1'b0; hold_left--; end
            else if (hold_started) begin
                out_ready = 1'b1;
                if (!released) begin released = 1; release_cyc = cyc; end
            end else out_ready = 1'b0;
        end
        if (out_valid && out_ready) begin
            check("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("res_row", out_row, e.r);
                check("res_col", out_col, e.c);
                check("res_data", out_data, e.d);
            end
        end
        prev_gr = gon_ready; prev_ge = gon_enable; prev_rt = row_tag; prev_ct = col_tag;
        prev_ov = out_valid; prev_or = out_ready; prev_row = out_row; prev_col = out_col;
        prev_data = out_data;
        start = (poke_cyc >= 0) && (cyc == poke_cyc) && busy;
        if (start) begin num_rows = 1; num_cols = 1; skip_cfg = 1'b1; end
    endtask

    task automatic clear_track();
        row_idx = 0; id_idx = 0; last_id_cyc = 0; first_req_cyc = 0; first_valid_cyc = 0;
        done_cnt = 0; first_req_seen = 0; first_valid_seen = 0; first_r = '0; first_c = '0;
        hold_started = 0; released = 0; rel_measured = 0; hold_left = 0; release_cyc = 0;
    endtask

    task automatic run_job(input int nr, input int nc, input bit skip, input int rmode,
                           input int rpct, input int poke_at, input int max_cyc, input bit tmo_first);
        int enr, enc, t0;
        enr = (nr == 0) ? 1 : ((nr > XB) ? XB : nr);
        enc = (nc == 0) ? 1 : ((nc > PE) ? PE : nc);
        salt = 16'($urandom);
        exp_q.delete();
        for (int r = 0; r < enr; r++)
            for (int c = 0; c < enc; c++)
                exp_q.push_back({RL'(r), IDL'(c), gon_val(RL'(r), IDL'(c))});
        if (tmo_first) exp_q[0].d = 32'hDEAD_BEEF;
        clear_track();
        ready_mode = rmode; ready_pct = rpct; mute_00 = tmo_first;
        num_rows = RL'(nr); num_cols = IDL'(nc); skip_cfg = skip;
        poke_cyc = (poke_at > 0) ? cyc + poke_at : -1;
        start = 1'b1;
        t0 = cyc;
        while (done_cnt == 0 && (cyc - t0) < max_cyc) cycle();
        check("job_done", done_cnt, 1);
        check("busy_at_done", busy, 0);
        check("exp_drained", exp_q.size(), 0);
        check("first_req_seen", first_req_seen, 1);
        check("first_req_tag", {first_r, first_c}, 0);
        if (!skip) begin
            check("row_scan_cnt", row_idx, XB);
            check("id_scan_cnt", id_idx, XB * PE);
            check("settle_gap", (first_req_cyc - last_id_cyc - 1) inside {[2:3]}, 1);
        end else begin
            check("no_scan", {row_idx[15:0], id_idx[15:0]}, 0);
        end
        cycle();
        check("done_pulse", done, 0);
        mute_00 = 0; poke_cyc = -1;
    endtask

    task automatic async_reset(input string pfx);
        #2;
        rst = 1'b0; start = 1'b0; gon_enable = 1'b0;
        #1;
        check_zero(pfx);
        @(negedge clk);
        rst = 1'b1;
        prev_gr = 0; prev_ge = 0; prev_ov = 0; prev_or = 0; lat = 0;
    endtask

    initial begin
        int n;
        clear_track();
        #3 rst = 1'b0;
        #10;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Full 12x14 with scan, always-ready sink
        run_job(12, 14, 0, 1, 100, 0, 5000, 0);
        // Small window, scan skipped
        run_job(2, 3, 1, 1, 100, 0, 500, 0);
        // Back-pressure hold after first result
        run_job(1, 3, 1, 2, 0, 0, 500, 0);
        check("release_req_seen", rel_measured, 1);

        // Abort during SCAN_ID, then restart cleanly (with a start poke while busy)
        exp_q.delete(); clear_track(); poke_cyc = -1; ready_mode = 1;
        num_rows = 4; num_cols = 4; skip_cfg = 1'b0; start = 1'b1;
        n = 0;
        while (!set_id && n < 100) begin cycle(); n++; end
        check("reached_scan_id", set_id, 1);
        repeat (5) cycle();
        async_reset("rst_scan_id");
        run_job(3, 2, 0, 0, 70, 50, 3000, 0);

        // Abort while a request is outstanding
        exp_q.delete(); clear_track(); mute_all = 1; ready_mode = 1;
        num_rows = 2; num_cols = 2; skip_cfg = 1'b1; start = 1'b1;
        n = 0;
        while (!gon_ready && n < 20) begin cycle(); n++; end
        check("reached_req", gon_ready, 1);
        repeat (3) cycle();
        async_reset("rst_req");
        mute_all = 0;
        run_job(2, 2, 0, 0, 80, 0, 3000, 0);

        // Clamping of zero and oversized window sizes
        run_job(0, 0, 1, 1, 100, 0, 200, 0);
        run_job(15, 31, 1, 0, 60, 40, 8000, 0);

        // Random windows and sink throttling
        for (int i = 0; i < 4; i++)
            run_job($urandom_range(0, 15), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                    0, $urandom_range(40, 100), 10, 8000, 0);

`ifdef GON_SCHED_TIMEOUT_EN
        run_job(1, 2, 1, 1, 100, 0, 3000, 1);
        check("tmo_delay", (first_valid_cyc - first_req_cyc) inside {[1022:1026]}, 1);
        check("tmo_err_set", timeout_err, 1);
        run_job(1, 1, 1, 1, 100, 0, 200, 0);
        check("tmo_err_clr", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
